// File: rtl/mod_n_counter_pkg.sv
// Shared types and elaboration helpers for the mod-N sequencing counter.
package mod_n_counter_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  // ceil(log2(n)), but never below 1 so that a 1-bit vector is always legal.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >>> 1) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mod_n_prescaler.sv
// Step-strobe generator: one step for every PRESCALE enabled cycles.
module mod_n_prescaler
  import mod_n_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic step
);

  generate
    if (PRESCALE <= 1) begin : g_pass
      logic unused_pass;
      assign unused_pass = &{1'b0, clk, rst, sync_clr};
      assign step = en;
    end else begin : g_div
      localparam int PW = clog2_min1(PRESCALE);
      localparam logic [PW-1:0] PHASE_LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] phase_q;
      logic [PW-1:0] phase_d;

      // Unreachable phase encodings simply count up and overflow back to 0.
      always_comb begin
        phase_d = phase_q;
        if (sync_clr) begin
          phase_d = '0;
        end else if (en) begin
          phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          phase_q <= '0;
        end else begin
          phase_q <= phase_d;
        end
      end

      assign step = en && (phase_q == PHASE_LAST);
    end
  endgenerate

endmodule

// File: rtl/mod_n_counter_fsm.sv
// Modulo-MODULUS up/down counter with load, clear, prescaling and one-shot halt;
// the registered wrap pulse lets instances be cascaded.
module mod_n_counter_fsm
  import mod_n_counter_pkg::*;
#(
  parameter int MODULUS  = 3,
  parameter int WIDTH    = clog2_min1(MODULUS),
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             one_shot,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] COUNT_LAST = WIDTH'(MODULUS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             load_err_q, load_err_d;

  logic step;
  logic at_term;
  logic load_ok;
  logic count_bad;

  // Range checks only exist when WIDTH has spare encodings above MODULUS-1.
  generate
    if ((1 << WIDTH) > MODULUS) begin : g_sparse
      assign load_ok   = (load_val <= COUNT_LAST);
      assign count_bad = (count_q > COUNT_LAST);
    end else begin : g_dense
      assign load_ok   = 1'b1;
      assign count_bad = 1'b0;
    end
  endgenerate

  assign at_term = up_dn ? (count_q == COUNT_LAST) : (count_q == '0);

  // Clear and load own the cycle, so the prescaler neither advances nor steps then.
  mod_n_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en & ~clear & ~load),
    .sync_clr (clear | (load & load_ok)),
    .step     (step)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;

    if (clear) begin
      count_d = '0;
      state_d = RUN;
    end else if (load) begin
      if (load_ok) begin
        count_d = load_val;
        state_d = RUN;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (count_bad) begin
      count_d = '0;
    end else if (step && (state_q == RUN)) begin
      if (at_term) begin
        if (one_shot) begin
          state_d = HALT;
        end else begin
          count_d = up_dn ? '0 : COUNT_LAST;
          wrap_d  = 1'b1;
        end
      end else begin
        count_d = up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end

    done_d = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      count_q    <= '0;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign tc       = at_term;
  assign wrap     = wrap_q;
  assign done     = done_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_mod_n_counter_fsm.sv
// Scoreboard bench: three counter configurations share one stimulus stream.
module tb_mod_n_counter_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up_dn, one_shot, clear, load;
  logic [2:0] load_val;

  logic [1:0] count_a, count_c;
  logic [2:0] count_b;
  logic       tc_a, wrap_a, done_a, lerr_a;
  logic       tc_b, wrap_b, done_b, lerr_b;
  logic       tc_c, wrap_c, done_c, lerr_c;

  always #5 clk = ~clk;

  // A: MODULUS=3 PRESCALE=1, B: MODULUS=5 PRESCALE=1, C: MODULUS=3 PRESCALE=3
  mod_n_counter_fsm #(.MODULUS(3), .PRESCALE(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .one_shot(one_shot),
    .clear(clear), .load(load), .load_val(load_val[1:0]),
    .count(count_a), .tc(tc_a), .wrap(wrap_a), .done(done_a), .load_err(lerr_a)
  );

  mod_n_counter_fsm #(.MODULUS(5), .PRESCALE(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .one_shot(one_shot),
    .clear(clear), .load(load), .load_val(load_val),
    .count(count_b), .tc(tc_b), .wrap(wrap_b), .done(done_b), .load_err(lerr_b)
  );

  mod_n_counter_fsm #(.MODULUS(3), .PRESCALE(3)) u_c (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .one_shot(one_shot),
    .clear(clear), .load(load), .load_val(load_val[1:0]),
    .count(count_c), .tc(tc_c), .wrap(wrap_c), .done(done_c), .load_err(lerr_c)
  );

  typedef struct {
    int         sel;
    logic [6:0] exp;   // {count[2:0], tc, wrap, done, load_err}
    string      name;
  } item_t;

  item_t sb_q[$];
  item_t mon_it;
  int    checks   = 0;
  int    failures = 0;

  function automatic logic [6:0] obs(input int sel);
    case (sel)
      0:       return {1'b0, count_a, tc_a, wrap_a, done_a, lerr_a};
      1:       return {count_b, tc_b, wrap_b, done_b, lerr_b};
      default: return {1'b0, count_c, tc_c, wrap_c, done_c, lerr_c};
    endcase
  endfunction

  task automatic check_obs(input int sel, input logic [6:0] exp, input string nm);
    logic [6:0] got;
    got = obs(sel);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got count=%0d tc=%b wrap=%b done=%b load_err=%b, expected count=%0d tc=%b wrap=%b done=%b load_err=%b",
               nm, sel, got[6:4], got[3], got[2], got[1], got[0],
               exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end else begin
      $display("ok   %s dut%0d: count=%0d tc=%b wrap=%b done=%b load_err=%b",
               nm, sel, got[6:4], got[3], got[2], got[1], got[0]);
    end
  endtask

  // Monitor: every expected item belongs to the clock edge that follows its push.
  always begin
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      mon_it = sb_q.pop_front();
      check_obs(mon_it.sel, mon_it.exp, mon_it.name);
    end
  end

  // Drive {en, up_dn, one_shot, clear, load} at a falling edge and queue the
  // expected outputs after the next rising edge.
  task automatic cyc(input int sel, input logic [4:0] in_v, input logic [2:0] lv,
                     input logic [6:0] exp, input string nm);
    item_t it;
    {en, up_dn, one_shot, clear, load} = in_v;
    load_val = lv;
    it.sel  = sel;
    it.exp  = exp;
    it.name = nm;
    sb_q.push_back(it);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    en       = 1'b0;
    up_dn    = 1'b1;
    one_shot = 1'b0;
    clear    = 1'b0;
    load     = 1'b0;
    load_val = 3'd0;
    #1;
    for (int s = 0; s < 3; s++) begin
      check_obs(s, 7'b000_0000, "reset");
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // MODULUS=3 counting up with wrap
    cyc(0, 5'b01000, 3'd0, {3'd0, 4'b0000}, "A idle");
    cyc(0, 5'b11000, 3'd0, {3'd1, 4'b0000}, "A up");
    cyc(0, 5'b11000, 3'd0, {3'd2, 4'b1000}, "A up tc");
    cyc(0, 5'b11000, 3'd0, {3'd0, 4'b0100}, "A wrap");
    cyc(0, 5'b11000, 3'd0, {3'd1, 4'b0000}, "A up");
    cyc(0, 5'b11000, 3'd0, {3'd2, 4'b1000}, "A up tc");
    cyc(0, 5'b11000, 3'd0, {3'd0, 4'b0100}, "A wrap");
    do_reset();

    // MODULUS=3 counting down
    cyc(0, 5'b00000, 3'd0, {3'd0, 4'b1000}, "B idle tc");
    cyc(0, 5'b10000, 3'd0, {3'd2, 4'b0100}, "B wrap down");
    cyc(0, 5'b10000, 3'd0, {3'd1, 4'b0000}, "B down");
    cyc(0, 5'b10000, 3'd0, {3'd0, 4'b1000}, "B down tc");
    cyc(0, 5'b10000, 3'd0, {3'd2, 4'b0100}, "B wrap down");
    do_reset();

    // MODULUS=5 one-shot
    cyc(1, 5'b11100, 3'd0, {3'd1, 4'b0000}, "C up");
    cyc(1, 5'b11100, 3'd0, {3'd2, 4'b0000}, "C up");
    cyc(1, 5'b11100, 3'd0, {3'd3, 4'b0000}, "C up");
    cyc(1, 5'b11100, 3'd0, {3'd4, 4'b1000}, "C up tc");
    cyc(1, 5'b11100, 3'd0, {3'd4, 4'b1010}, "C halt");
    cyc(1, 5'b11100, 3'd0, {3'd4, 4'b1010}, "C halt hold");
    cyc(1, 5'b10100, 3'd0, {3'd4, 4'b0010}, "C halt dir change");
    cyc(1, 5'b11110, 3'd0, {3'd0, 4'b0000}, "C clear");
    cyc(1, 5'b11100, 3'd0, {3'd1, 4'b0000}, "C resume");

    // MODULUS=5 load handling
    cyc(1, 5'b11001, 3'd3, {3'd3, 4'b0000}, "D load 3");
    cyc(1, 5'b11000, 3'd0, {3'd4, 4'b1000}, "D up tc");
    cyc(1, 5'b11000, 3'd0, {3'd0, 4'b0100}, "D wrap");
    cyc(1, 5'b01001, 3'd6, {3'd0, 4'b0001}, "D load 6 rejected");
    cyc(1, 5'b01000, 3'd0, {3'd0, 4'b0000}, "D load_err drops");
    cyc(1, 5'b11011, 3'd3, {3'd0, 4'b0000}, "D clear beats load");
    cyc(1, 5'b11000, 3'd0, {3'd1, 4'b0000}, "D up");
    cyc(1, 5'b01001, 3'd4, {3'd4, 4'b1000}, "D load 4");
    cyc(1, 5'b11000, 3'd0, {3'd0, 4'b0100}, "D wrap");
    do_reset();

    // MODULUS=3 PRESCALE=3 with en gaps
    cyc(2, 5'b11000, 3'd0, {3'd0, 4'b0000}, "E ph1");
    cyc(2, 5'b11000, 3'd0, {3'd0, 4'b0000}, "E ph2");
    cyc(2, 5'b11000, 3'd0, {3'd1, 4'b0000}, "E step");
    cyc(2, 5'b11000, 3'd0, {3'd1, 4'b0000}, "E ph1");
    cyc(2, 5'b01000, 3'd0, {3'd1, 4'b0000}, "E en off");
    cyc(2, 5'b01000, 3'd0, {3'd1, 4'b0000}, "E en off");
    cyc(2, 5'b11000, 3'd0, {3'd1, 4'b0000}, "E ph2");
    cyc(2, 5'b11000, 3'd0, {3'd2, 4'b1000}, "E step tc");
    cyc(2, 5'b11000, 3'd0, {3'd2, 4'b1000}, "E ph1");
    cyc(2, 5'b11000, 3'd0, {3'd2, 4'b1000}, "E ph2");
    cyc(2, 5'b11000, 3'd0, {3'd0, 4'b0100}, "E wrap");
    cyc(2, 5'b11000, 3'd0, {3'd0, 4'b0000}, "E ph1");
    cyc(2, 5'b11001, 3'd1, {3'd1, 4'b0000}, "E load restarts");
    cyc(2, 5'b11000, 3'd0, {3'd1, 4'b0000}, "E ph1");
    cyc(2, 5'b11000, 3'd0, {3'd1, 4'b0000}, "E ph2");
    cyc(2, 5'b11000, 3'd0, {3'd2, 4'b1000}, "E step tc");

    // Asynchronous reset between edges, prescaler mid-phase
    cyc(2, 5'b11000, 3'd0, {3'd2, 4'b1000}, "F ph1");
    #2;
    do_reset();
    cyc(2, 5'b11000, 3'd0, {3'd0, 4'b0000}, "F ph1");
    cyc(2, 5'b11000, 3'd0, {3'd0, 4'b0000}, "F ph2");
    cyc(2, 5'b11000, 3'd0, {3'd1, 4'b0000}, "F step");

    repeat (2) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d items left, expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
